// File: rtl/prm_edge_mask_accum.sv
// Blocked-edge bitmap collector: ORs per-point edge masks over a frame and
// presents the frame's bitmap, popcount and point count through a
// valid/ready result buffer.
module prm_edge_mask_accum #(
    parameter int unsigned NUM_EDGES = 256,
    parameter int unsigned PT_CNT_W  = 16,
    parameter int unsigned CNT_W     = 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pt_valid,
    output logic                 pt_ready,
    input  logic                 pt_last,
    input  logic [NUM_EDGES-1:0] edge_mask_in,
    input  logic                 frame_abort,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NUM_EDGES-1:0] out_blocked,
    output logic [CNT_W-1:0]     out_blk_cnt,
    output logic [PT_CNT_W-1:0]  out_pt_cnt
);

    typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

    state_t                state_q, state_d;
    logic                  s1_valid_q, s1_last_q;
    logic [NUM_EDGES-1:0]  s1_mask_q;
    logic [NUM_EDGES-1:0]  acc_q, acc_d, acc_new;
    logic [PT_CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic                  out_valid_q;
    logic [NUM_EDGES-1:0]  out_blocked_q;
    logic [CNT_W-1:0]      out_blk_cnt_q;
    logic [PT_CNT_W-1:0]   out_pt_cnt_q;
    logic                  buf_free, pt_fire, load;
    logic [NUM_EDGES-1:0]  load_mask;
    logic [PT_CNT_W-1:0]   load_cnt;

    function automatic logic [CNT_W-1:0] popcount(input logic [NUM_EDGES-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < int'(NUM_EDGES); i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    // Shared handshake and accumulation terms
    assign acc_new  = acc_q | s1_mask_q;
    assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + PT_CNT_W'(1);
    assign buf_free = !out_valid_q || out_ready;
    // One bubble after a last point so the frame boundary settles before new points enter
    assign pt_ready = rst_n && !frame_abort && (state_q == ACCUM) && !(s1_valid_q && s1_last_q);
    assign pt_fire  = pt_valid && pt_ready;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: park in HOLD while a finished frame waits for the buffer
    always_comb begin
        state_d = state_q;
        if (frame_abort) begin
            state_d = ACCUM;
        end else begin
            case (state_q)
                ACCUM: if (s1_valid_q && s1_last_q && !buf_free) state_d = HOLD;
                HOLD:  if (buf_free) state_d = ACCUM;
                default: state_d = ACCUM;
            endcase
        end
    end

    // FSM outputs: accumulator update and result-buffer load decision
    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        load      = 1'b0;
        load_mask = acc_new;
        load_cnt  = cnt_inc;
        if (frame_abort) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (state_q == ACCUM) begin
            if (s1_valid_q) begin
                if (s1_last_q && buf_free) begin
                    load  = 1'b1;
                    acc_d = '0;
                    cnt_d = '0;
                end else begin
                    acc_d = acc_new;
                    cnt_d = cnt_inc;
                end
            end
        end else if (buf_free) begin
            load      = 1'b1;
            load_mask = acc_q;
            load_cnt  = cnt_q;
            acc_d     = '0;
            cnt_d     = '0;
        end
    end

    // Input stage, accumulator and counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_mask_q  <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= pt_fire;
            if (pt_fire) begin
                s1_last_q <= pt_last;
                s1_mask_q <= edge_mask_in;
            end
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    // Result buffer: a load replaces the contents even when popped the same cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q   <= 1'b0;
            out_blocked_q <= '0;
            out_blk_cnt_q <= '0;
            out_pt_cnt_q  <= '0;
        end else if (load) begin
            out_valid_q   <= 1'b1;
            out_blocked_q <= load_mask;
            out_blk_cnt_q <= popcount(load_mask);
            out_pt_cnt_q  <= load_cnt;
        end else if (out_ready) begin
            out_valid_q   <= 1'b0;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_blocked = out_blocked_q;
    assign out_blk_cnt = out_blk_cnt_q;
    assign out_pt_cnt  = out_pt_cnt_q;

endmodule

// File: tb/tb_prm_edge_mask_accum.sv
// Directed and randomized checks of the edge-mask accumulator with a
// result scoreboard fed at stimulus time.
module tb_prm_edge_mask_accum;

    localparam int unsigned NE  = 16;
    localparam int unsigned PCW = 4;
    localparam int unsigned CW  = 5;

    typedef struct packed {
        logic [NE-1:0]  blk;
        logic [CW-1:0]  bcnt;
        logic [PCW-1:0] pcnt;
    } res_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           pt_valid, pt_ready, pt_last, frame_abort;
    logic [NE-1:0]  edge_mask_in;
    logic           out_valid, out_ready;
    logic [NE-1:0]  out_blocked;
    logic [CW-1:0]  out_blk_cnt;
    logic [PCW-1:0] out_pt_cnt;

    int   total = 0;
    int   bad   = 0;
    res_t exp_q[$];
    bit   rnd_rdy = 1'b0;

    prm_edge_mask_accum #(.NUM_EDGES(NE), .PT_CNT_W(PCW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .pt_valid(pt_valid), .pt_ready(pt_ready),
        .pt_last(pt_last), .edge_mask_in(edge_mask_in), .frame_abort(frame_abort),
        .out_valid(out_valid), .out_ready(out_ready), .out_blocked(out_blocked),
        .out_blk_cnt(out_blk_cnt), .out_pt_cnt(out_pt_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CW-1:0] pop16(input logic [NE-1:0] v);
        logic [CW-1:0] c = '0;
        for (int i = 0; i < int'(NE); i++) c = c + CW'(v[i]);
        return c;
    endfunction

    // Scoreboard: pop and compare on every result transfer; also check hold stability
    res_t prev_r;
    bit   prev_stall = 1'b0;
    always @(negedge clk) begin
        res_t e;
        if (prev_stall) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", 32'({out_blocked, out_blk_cnt, out_pt_cnt}), 32'(prev_r));
        end
        prev_stall = rst_n && out_valid && !out_ready;
        prev_r     = {out_blocked, out_blk_cnt, out_pt_cnt};
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 32'(out_blocked), 32'hDEAD);
            end else begin
                e = exp_q.pop_front();
                chk("out_blocked", 32'(out_blocked), 32'(e.blk));
                chk("out_blk_cnt", 32'(out_blk_cnt), 32'(e.bcnt));
                chk("out_pt_cnt",  32'(out_pt_cnt),  32'(e.pcnt));
            end
        end
    end

    // Random consumer back-pressure during the soak phase
    always @(posedge clk) begin
        if (rnd_rdy) begin
            #1 out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input logic [NE-1:0] m, input logic last);
        int n = 0;
        pt_valid = 1'b1; edge_mask_in = m; pt_last = last;
        forever begin
            @(negedge clk);
            if (pt_ready) break;
            n++;
            if (n > 200) begin
                chk("pt_ready_timeout", 32'(pt_ready), 32'd1);
                break;
            end
        end
        @(posedge clk); #1;
        pt_valid = 1'b0; pt_last = 1'b0; edge_mask_in = $urandom();
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk); n++;
        end
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [NE-1:0]  acc;
        logic [PCW-1:0] pc;
        int             len;
        logic [NE-1:0]  m;

        rst_n = 1'b0; pt_valid = 1'b0; pt_last = 1'b0; edge_mask_in = '0;
        frame_abort = 1'b0; out_ready = 1'b0;

        // 1: reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_blocked", 32'(out_blocked), 32'd0);
        chk("rst_pt_ready", 32'(pt_ready), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_pt_ready", 32'(pt_ready), 32'd1);
        @(posedge clk); #1;

        // 2: basic frame and latency
        out_ready = 1'b1;
        exp_q.push_back('{16'h8011, 5'd3, 4'd3});
        send(16'h0001, 1'b0);
        send(16'h0010, 1'b0);
        send(16'h8000, 1'b1);
        @(negedge clk);
        chk("lat_t1_valid", 32'(out_valid), 32'd0);
        chk("bubble_pt_ready", 32'(pt_ready), 32'd0);
        @(negedge clk);
        chk("lat_t2_valid", 32'(out_valid), 32'd1);
        drain("drain_basic");

        // 3: buffer full -> HOLD, then both frames delivered in order
        @(posedge clk); #1 out_ready = 1'b0;
        exp_q.push_back('{16'h00F0, 5'd4, 4'd1});
        exp_q.push_back('{16'h0F01, 5'd5, 4'd2});
        send(16'h00F0, 1'b1);
        send(16'h0F00, 1'b0);
        send(16'h0001, 1'b1);
        repeat (3) @(negedge clk);
        chk("hold_pt_ready", 32'(pt_ready), 32'd0);
        chk("hold_buf_a", 32'(out_blocked), 32'h00F0);
        @(posedge clk); #1 out_ready = 1'b1;
        drain("drain_hold");
        @(negedge clk);
        chk("hold_after_valid", 32'(out_valid), 32'd0);

        // 4: abort discards partial frame
        send(16'hFFFF, 1'b0);
        send(16'hFFFF, 1'b0);
        frame_abort = 1'b1; pt_valid = 1'b1; edge_mask_in = 16'h4000;
        @(negedge clk);
        chk("abort_pt_ready", 32'(pt_ready), 32'd0);
        @(posedge clk); #1 frame_abort = 1'b0; pt_valid = 1'b0;
        exp_q.push_back('{16'h0002, 5'd1, 4'd1});
        send(16'h0002, 1'b1);
        drain("drain_abort");

        // 5: point counter saturation
        exp_q.push_back('{16'h0000, 5'd0, 4'd15});
        for (int i = 0; i < 19; i++) send(16'h0000, 1'b0);
        send(16'h0000, 1'b1);
        drain("drain_sat");

        // 6: random frames with gaps and back-pressure
        rnd_rdy = 1'b1;
        for (int f = 0; f < 500; f++) begin
            len = $urandom_range(1, 6);
            if (f % 50 == 0) len = 18;
            acc = '0; pc = '0;
            for (int p = 0; p < len; p++) begin
                m = NE'($urandom()) & NE'($urandom());
                acc = acc | m;
                if (pc != '1) pc = pc + 4'd1;
                if (p == len - 1) exp_q.push_back('{acc, pop16(acc), pc});
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                send(m, 1'(p == len - 1));
            end
        end
        rnd_rdy = 1'b0;
        @(posedge clk); #2 out_ready = 1'b1;
        drain("drain_random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
